// File: rtl/agc_pwm_ctrl.sv
// ============================================================================
// agc_pwm_ctrl
// ----------------------------------------------------------------------------
// AGC gain-control PWM generator. Each accepted power estimate is compared
// against the requested level. When the loop is acquiring and the error is
// outside the lock window, the duty word is stepped toward the request. The
// step is fine or coarse, depending on the error magnitude. The word
// saturates at programmable bounds. A lock/unlock state machine with
// hysteresis freezes the word once the loop has settled.
//
// Optional feature macro:
//   AGC_UNLOCK_EN - when defined, a run of UNLOCK_N consecutive estimates
//                   outside the unlock window drops LOCKED back to ACQ.
//                   When undefined, LOCKED is sticky until manual mode or
//                   reset.
//
// Ports:
//   clk              - single clock
//   reset            - asynchronous, active-high reset
//   pwr_req_val      - requested power, unsigned dB
//   pwr_est_dB       - estimated power, unsigned dB
//   pwr_est_end      - one-cycle strobe marking a valid estimate
//   pwr_range        - lock window half-width
//   pwr_unlock_range - unlock window half-width
//   coarse_th        - |error| above this selects the coarse step
//   pwm_step_fine    - fine step size
//   pwm_step_coarse  - coarse step size
//   pwm_ena          - closed-loop enable
//   pwm_inv          - invert gain polarity
//   pwm_th_ena       - force manual load
//   pwm_th_in        - manual duty value
//   pwm_max_val      - upper clamp
//   pwm_min_val      - lower clamp
//   pwm_val          - duty word
//   pwm_val_up       - one-cycle update strobe
//   agc_fix          - high while LOCKED
//   agc_state        - MANUAL=0, ACQ=1, LOCKED=2
// ============================================================================
module agc_pwm_ctrl #(
    parameter int PWM_W    = 8,
    parameter int DB_W     = 9,
    parameter int RNG_W    = 8,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DB_W-1:0]  pwr_req_val,
    input  logic [DB_W-1:0]  pwr_est_dB,
    input  logic             pwr_est_end,
    input  logic [RNG_W-1:0] pwr_range,
    input  logic [RNG_W-1:0] pwr_unlock_range,
    input  logic [DB_W-1:0]  coarse_th,
    input  logic [3:0]       pwm_step_fine,
    input  logic [3:0]       pwm_step_coarse,
    input  logic             pwm_ena,
    input  logic             pwm_inv,
    input  logic             pwm_th_ena,
    input  logic [PWM_W-1:0] pwm_th_in,
    input  logic [PWM_W-1:0] pwm_max_val,
    input  logic [PWM_W-1:0] pwm_min_val,
    output logic [PWM_W-1:0] pwm_val,
    output logic             pwm_val_up,
    output logic             agc_fix,
    output logic [1:0]       agc_state
);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    logic [CNT_W-1:0] unlock_cnt_q;
    logic [CNT_W-1:0] unlock_cnt_d;
    logic             adj_d;

    logic [DB_W:0]    delta;
    logic [DB_W-1:0]  err_abs;
    logic             in_rng;
    logic             out_win;
    logic             err_pos;
    logic             dir_up;
    logic [3:0]       step_sel;
    logic             manual_req;
    logic             accept;

    // Pipeline stage between the estimate edge and the duty-word edge
    logic             upd_pend_q;
    logic             adj_en_q;
    logic             adj_up_q;
    logic [3:0]       adj_step_q;

    logic [PWM_W:0]   sum_w;
    logic [PWM_W:0]   diff_w;
    logic [PWM_W-1:0] pwm_next;

    // Error is one bit wider than the operands so that the sign survives.
    // The magnitude of a difference of two DB_W-bit unsigned values always
    // fits back into DB_W bits.
    assign delta   = {1'b0, pwr_req_val} - {1'b0, pwr_est_dB};
    assign err_abs = delta[DB_W] ? DB_W'((DB_W+1)'(0) - delta) : delta[DB_W-1:0];
    assign in_rng  = (err_abs <= DB_W'(pwr_range));
    assign out_win = (err_abs > DB_W'(pwr_unlock_range));
    assign err_pos = !delta[DB_W] && (delta != '0);
    assign dir_up  = err_pos ^ pwm_inv;
    assign step_sel = (err_abs > coarse_th) ? pwm_step_coarse : pwm_step_fine;

    // Manual mode wins over everything, so an estimate arriving in the same
    // cycle as a manual request is never accepted.
    assign manual_req = !pwm_ena || pwm_th_ena;
    assign accept     = pwr_est_end && (state_q != ST_MANUAL) && !manual_req;

    assign agc_state = state_q;

    // State, counters and the registered lock flag. agc_fix follows the
    // next state, so it rises on the same edge that enters LOCKED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_MANUAL;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            agc_fix      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            agc_fix      <= (state_d == ST_LOCKED);
        end
    end

    // Next-state and counter logic. Counters are cleared whenever the loop
    // is in or is entering manual mode, so that each acquisition starts
    // clean.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        adj_d        = 1'b0;

        if (manual_req) begin
            state_d      = ST_MANUAL;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    state_d      = ST_ACQ;
                    lock_cnt_d   = '0;
                    unlock_cnt_d = '0;
                end
                ST_ACQ: begin
                    if (accept) begin
                        if (in_rng) begin
                            if (lock_cnt_q == CNT_W'(LOCK_N - 1)) begin
                                state_d      = ST_LOCKED;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else begin
                                lock_cnt_d = lock_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            lock_cnt_d = '0;
                            adj_d      = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
`ifdef AGC_UNLOCK_EN
                        if (out_win) begin
                            if (unlock_cnt_q == CNT_W'(UNLOCK_N - 1)) begin
                                state_d      = ST_ACQ;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else begin
                                unlock_cnt_d = unlock_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            unlock_cnt_d = '0;
                        end
`else
                        // The counter still tracks out-of-window runs, but
                        // it saturates and never releases the lock.
                        if (out_win) begin
                            if (unlock_cnt_q != CNT_W'(UNLOCK_N - 1)) begin
                                unlock_cnt_d = unlock_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            unlock_cnt_d = '0;
                        end
`endif
                    end
                end
                default: begin
                    state_d      = ST_MANUAL;
                    lock_cnt_d   = '0;
                    unlock_cnt_d = '0;
                end
            endcase
        end
    end

    // Capture the adjust decision on the estimate edge. Every accepted
    // estimate produces an update strobe one edge later, even when no
    // adjustment is applied, such as in LOCKED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_pend_q <= 1'b0;
            adj_en_q   <= 1'b0;
            adj_up_q   <= 1'b0;
            adj_step_q <= '0;
        end else begin
            upd_pend_q <= accept;
            adj_en_q   <= adj_d;
            adj_up_q   <= dir_up;
            adj_step_q <= step_sel;
        end
    end

    // Saturating step computed one bit wide so that carry and borrow are
    // visible. A word that is already outside [min,max] is pulled back
    // into range by the next adjustment, whichever direction it takes.
    always_comb begin
        sum_w    = {1'b0, pwm_val} + (PWM_W+1)'(adj_step_q);
        diff_w   = {1'b0, pwm_val} - (PWM_W+1)'(adj_step_q);
        pwm_next = pwm_val;
        if (adj_up_q) begin
            if (sum_w[PWM_W] || (sum_w[PWM_W-1:0] > pwm_max_val)) begin
                pwm_next = pwm_max_val;
            end else if (sum_w[PWM_W-1:0] < pwm_min_val) begin
                pwm_next = pwm_min_val;
            end else begin
                pwm_next = sum_w[PWM_W-1:0];
            end
        end else begin
            if (diff_w[PWM_W] || (diff_w[PWM_W-1:0] < pwm_min_val)) begin
                pwm_next = pwm_min_val;
            end else if (diff_w[PWM_W-1:0] > pwm_max_val) begin
                pwm_next = pwm_max_val;
            end else begin
                pwm_next = diff_w[PWM_W-1:0];
            end
        end
    end

    // Duty word and update strobe. A manual request in the update cycle
    // discards the pending result and loads the manual value instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_val    <= '0;
            pwm_val_up <= 1'b0;
        end else if (manual_req) begin
            pwm_val    <= pwm_th_in;
            pwm_val_up <= 1'b0;
        end else begin
            pwm_val_up <= upd_pend_q;
            if (upd_pend_q && adj_en_q) begin
                pwm_val <= pwm_next;
            end
        end
    end

endmodule
